pad_link_gearbox: RTL and testbench

//  Parametrised pad-side link between narrow chip I/O pins and the word-wide kd-tree/query load
//  and result paths. Deserialises PAD_WIDTH-bit beats into DATA_WIDTH words, with valid/ready flow

---
 rtl/pad_link_pkg.sv | 10 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/pad_link_gearbox.sv | 196 +++++++++++++++++++
 tb/tb_pad_link_gearbox.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_link_pkg.sv
// Shared types and helpers for the pad-side link gearbox.
package pad_link_pkg;

    typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;

    function automatic int beats(input int dw, input int pw);
        return (dw + pw - 1) / pw;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with full/empty flags and a flush input.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty    = (wr_q == rd_q);
    assign pop_data = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push && !full) wr_d = wr_q + (AW+1)'(1);
            if (pop && !empty) rd_d = rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !flush) mem_q[wr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/pad_link_gearbox.sv
// Pad-side gearbox: deserialises pin beats into core words and serialises result words onto pins.
module pad_link_gearbox
    import pad_link_pkg::*;
#(
    parameter int DATA_WIDTH = 11,
    parameter int PAD_WIDTH  = 4,
    parameter int IN_DEPTH   = 4,
    parameter int OUT_DEPTH  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  cfg_msb_first,
    input  logic                  cfg_flush,
    input  logic                  pad_in_valid,
    input  logic [PAD_WIDTH-1:0]  pad_in_data,
    output logic                  pad_in_ready,
    output logic                  core_in_valid,
    output logic [DATA_WIDTH-1:0] core_in_data,
    input  logic                  core_in_ready,
    input  logic                  core_out_valid,
    input  logic [DATA_WIDTH-1:0] core_out_data,
    output logic                  core_out_ready,
    output logic                  pad_out_valid,
    output logic [PAD_WIDTH-1:0]  pad_out_data,
    input  logic                  pad_out_ready,
    output logic [CNT_WIDTH-1:0]  in_word_count,
    output logic [CNT_WIDTH-1:0]  out_word_count
);
    localparam int BEATS = beats(DATA_WIDTH, PAD_WIDTH);
    localparam int WW    = BEATS * PAD_WIDTH;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

    function automatic logic [PAD_WIDTH-1:0] slice_of(input logic [WW-1:0] w, input logic msb,
                                                      input logic [BCW-1:0] beat);
        int idx;
        idx = msb ? (BEATS - 1 - int'(beat)) : int'(beat);
        return w[idx*PAD_WIDTH +: PAD_WIDTH];
    endfunction

    logic                  in_full, in_empty, in_push, in_accept, in_beat_msb;
    logic [DATA_WIDTH-1:0] in_push_data;
    logic [BCW-1:0]        in_beat_q, in_beat_d;
    logic                  in_msb_q, in_msb_d;
    logic [WW-1:0]         in_word_q, in_word_d;
    logic [CNT_WIDTH-1:0]  in_cnt_q, in_cnt_d;
    int                    in_idx;

    logic                  out_full, out_empty, out_pop, out_load, out_last;
    logic [DATA_WIDTH-1:0] out_head;
    ser_state_t            state_q, state_d;
    logic [BCW-1:0]        out_beat_q, out_beat_d;
    logic                  out_msb_q, out_msb_d;
    logic [WW-1:0]         out_word_q, out_word_d;
    logic                  pad_out_valid_q, pad_out_valid_d;
    logic [PAD_WIDTH-1:0]  pad_out_data_q, pad_out_data_d;
    logic [CNT_WIDTH-1:0]  out_cnt_q, out_cnt_d;

    assign pad_in_ready   = (in_beat_q != LAST_BEAT) || !in_full;
    assign core_in_valid  = !in_empty;
    assign core_out_ready = !out_full;
    assign pad_out_valid  = pad_out_valid_q;
    assign pad_out_data   = pad_out_data_q;
    assign in_word_count  = in_cnt_q;
    assign out_word_count = out_cnt_q;

    // Beat order is taken live on beat 0 and held for the rest of the word.
    always_comb begin
        in_accept    = pad_in_valid && pad_in_ready && !cfg_flush;
        in_beat_msb  = (in_beat_q == '0) ? cfg_msb_first : in_msb_q;
        in_idx       = in_beat_msb ? (BEATS - 1 - int'(in_beat_q)) : int'(in_beat_q);
        in_word_d    = in_word_q;
        in_beat_d    = in_beat_q;
        in_msb_d     = in_msb_q;
        in_push      = 1'b0;
        if (cfg_flush) begin
            in_beat_d = '0;
        end else if (in_accept) begin
            in_word_d[in_idx*PAD_WIDTH +: PAD_WIDTH] = pad_in_data;
            in_msb_d = in_beat_msb;
            if (in_beat_q == LAST_BEAT) begin
                in_push   = 1'b1;
                in_beat_d = '0;
            end else begin
                in_beat_d = in_beat_q + BCW'(1);
            end
        end
        in_push_data = in_word_d[DATA_WIDTH-1:0];
        in_cnt_d     = (in_push && (in_cnt_q != '1)) ? in_cnt_q + CNT_WIDTH'(1) : in_cnt_q;
    end

    always_comb begin
        state_d         = state_q;
        out_beat_d      = out_beat_q;
        out_msb_d       = out_msb_q;
        out_word_d      = out_word_q;
        pad_out_valid_d = pad_out_valid_q;
        pad_out_data_d  = pad_out_data_q;
        out_load        = 1'b0;
        out_last        = 1'b0;
        out_pop         = 1'b0;
        if (cfg_flush) begin
            state_d         = SER_IDLE;
            out_beat_d      = '0;
            pad_out_valid_d = 1'b0;
            pad_out_data_d  = '0;
        end else begin
            case (state_q)
                SER_IDLE: out_load = !out_empty;
                SER_SHIFT: begin
                    if (pad_out_ready) begin
                        if (out_beat_q == LAST_BEAT) begin
                            out_last = 1'b1;
                            if (!out_empty) begin
                                out_load = 1'b1;
                            end else begin
                                state_d         = SER_IDLE;
                                pad_out_valid_d = 1'b0;
                                pad_out_data_d  = '0;
                            end
                        end else begin
                            out_beat_d     = out_beat_q + BCW'(1);
                            pad_out_data_d = slice_of(out_word_q, out_msb_q, out_beat_d);
                        end
                    end
                end
                default: state_d = SER_IDLE;
            endcase
        end
        // Reloading straight from the FIFO head keeps back-to-back words bubble-free.
        if (out_load) begin
            out_pop         = 1'b1;
            out_word_d      = WW'(out_head);
            out_msb_d       = cfg_msb_first;
            out_beat_d      = '0;
            state_d         = SER_SHIFT;
            pad_out_valid_d = 1'b1;
            pad_out_data_d  = slice_of(out_word_d, cfg_msb_first, '0);
        end
        out_cnt_d = (out_last && (out_cnt_q != '1)) ? out_cnt_q + CNT_WIDTH'(1) : out_cnt_q;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            in_beat_q       <= '0;
            in_msb_q        <= 1'b0;
            in_word_q       <= '0;
            in_cnt_q        <= '0;
            state_q         <= SER_IDLE;
            out_beat_q      <= '0;
            out_msb_q       <= 1'b0;
            out_word_q      <= '0;
            pad_out_valid_q <= 1'b0;
            pad_out_data_q  <= '0;
            out_cnt_q       <= '0;
        end else begin
            in_beat_q       <= in_beat_d;
            in_msb_q        <= in_msb_d;
            in_word_q       <= in_word_d;
            in_cnt_q        <= in_cnt_d;
            state_q         <= state_d;
            out_beat_q      <= out_beat_d;
            out_msb_q       <= out_msb_d;
            out_word_q      <= out_word_d;
            pad_out_valid_q <= pad_out_valid_d;
            pad_out_data_q  <= pad_out_data_d;
            out_cnt_q       <= out_cnt_d;
        end
    end

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .flush     (cfg_flush),
        .push      (in_push),
        .push_data (in_push_data),
        .pop       (core_in_ready && !in_empty),
        .pop_data  (core_in_data),
        .full      (in_full),
        .empty     (in_empty)
    );

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .flush     (cfg_flush),
        .push      (core_out_valid && !out_full),
        .push_data (core_out_data),
        .pop       (out_pop),
        .pop_data  (out_head),
        .full      (out_full),
        .empty     (out_empty)
    );

endmodule

// File: tb/tb_pad_link_gearbox.sv
// Randomised and directed bench for pad_link_gearbox against a queue-based reference model.
module tb_pad_link_gearbox;
    localparam int DW = 11, PW = 4, NB = 3, ID = 4, OD = 4, CW = 16;

    logic          clk = 1'b0;
    logic          rst, cfg_msb_first, cfg_flush;
    logic          pad_in_valid, pad_in_ready, core_in_valid, core_in_ready;
    logic [PW-1:0] pad_in_data, pad_out_data;
    logic [DW-1:0] core_in_data, core_out_data;
    logic          core_out_valid, core_out_ready, pad_out_valid, pad_out_ready;
    logic [CW-1:0] in_word_count, out_word_count;

    always #5 clk = ~clk;

    pad_link_gearbox #(.DATA_WIDTH(DW), .PAD_WIDTH(PW), .IN_DEPTH(ID), .OUT_DEPTH(OD),
                       .CNT_WIDTH(CW)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .cfg_msb_first(cfg_msb_first), .cfg_flush(cfg_flush),
        .pad_in_valid(pad_in_valid), .pad_in_data(pad_in_data), .pad_in_ready(pad_in_ready),
        .core_in_valid(core_in_valid), .core_in_data(core_in_data), .core_in_ready(core_in_ready),
        .core_out_valid(core_out_valid), .core_out_data(core_out_data),
        .core_out_ready(core_out_ready), .pad_out_valid(pad_out_valid),
        .pad_out_data(pad_out_data), .pad_out_ready(pad_out_ready),
        .in_word_count(in_word_count), .out_word_count(out_word_count)
    );

    int checks = 0, errors = 0;

    // Reference model: word FIFOs as queues, a partial-beat list and the beats left to send.
    int in_q[$], in_part[$], out_q[$], cur[$];
    bit in_mode;
    int m_in_cnt, m_out_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        in_q.delete(); in_part.delete(); out_q.delete(); cur.delete();
        m_in_cnt = 0; m_out_cnt = 0; in_mode = 0;
    endtask

    task automatic model_load();
        int w;
        w = out_q.pop_front();
        for (int k = 0; k < NB; k++) begin
            int pos;
            pos = cfg_msb_first ? NB - 1 - k : k;
            cur.push_back((w >> (pos * PW)) & ((1 << PW) - 1));
        end
    endtask

    task automatic model_edge();
        bit in_pop, in_acc, out_push;
        if (cfg_flush) begin
            in_q.delete(); in_part.delete(); out_q.delete(); cur.delete();
            return;
        end
        in_pop   = core_in_ready && in_q.size() > 0;
        in_acc   = pad_in_valid && (in_part.size() != NB - 1 || in_q.size() < ID);
        out_push = core_out_valid && out_q.size() < OD;
        if (cur.size() == 0) begin
            if (out_q.size() > 0) model_load();
        end else if (pad_out_ready) begin
            void'(cur.pop_front());
            if (cur.size() == 0) begin
                if (m_out_cnt < (1 << CW) - 1) m_out_cnt++;
                if (out_q.size() > 0) model_load();
            end
        end
        if (out_push) out_q.push_back(int'(core_out_data));
        if (in_pop) void'(in_q.pop_front());
        if (in_acc) begin
            if (in_part.size() == 0) in_mode = cfg_msb_first;
            in_part.push_back(int'(pad_in_data));
            if (in_part.size() == NB) begin
                int w;
                w = 0;
                for (int k = 0; k < NB; k++) begin
                    int pos;
                    pos = in_mode ? NB - 1 - k : k;
                    w = w | (in_part[k] << (pos * PW));
                end
                in_q.push_back(w & ((1 << DW) - 1));
                in_part.delete();
                if (m_in_cnt < (1 << CW) - 1) m_in_cnt++;
            end
        end
    endtask

    task automatic check_all();
        check_eq("pad_in_ready", pad_in_ready, in_part.size() != NB - 1 || in_q.size() < ID);
        check_eq("core_in_valid", core_in_valid, in_q.size() > 0);
        if (in_q.size() > 0) check_eq("core_in_data", core_in_data, in_q[0]);
        check_eq("core_out_ready", core_out_ready, out_q.size() < OD);
        check_eq("pad_out_valid", pad_out_valid, cur.size() > 0);
        if (cur.size() > 0) check_eq("pad_out_data", pad_out_data, cur[0]);
        check_eq("in_word_count", in_word_count, m_in_cnt);
        check_eq("out_word_count", out_word_count, m_out_cnt);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        cfg_flush = 0; pad_in_valid = 0; pad_in_data = '0; core_in_ready = 0;
        core_out_valid = 0; core_out_data = '0; pad_out_ready = 0;
    endtask

    task automatic send_beat(input logic [PW-1:0] d);
        pad_in_valid = 1; pad_in_data = d;
        step();
        pad_in_valid = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_pad_in_ready"}, pad_in_ready, 1);
        check_eq({tag, "_core_in_valid"}, core_in_valid, 0);
        check_eq({tag, "_core_out_ready"}, core_out_ready, 1);
        check_eq({tag, "_pad_out_valid"}, pad_out_valid, 0);
        check_eq({tag, "_pad_out_data"}, pad_out_data, 0);
        check_eq({tag, "_in_cnt"}, in_word_count, 0);
        check_eq({tag, "_out_cnt"}, out_word_count, 0);
    endtask

    task automatic scenario_lsb();
        cfg_msb_first = 0; core_in_ready = 1;
        send_beat(4'hB); send_beat(4'h7); send_beat(4'h5);
        check_eq("s1_data", core_in_data, 11'h57B);
        check_eq("s1_valid", core_in_valid, 1);
        check_eq("s1_count", in_word_count, m_in_cnt);
        step();
    endtask

    int obs[$];
    int exp_beats[6] = '{5, 'hA, 2, 'hF, 'hF, 7};
    logic [PW-1:0] held;
    logic [CW-1:0] saved_in, saved_out;
    int guard;

    initial begin
        idle_inputs();
        cfg_msb_first = 0;
        rst = 1;
        model_reset();
        #1 check_reset_outputs("rst0");
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Scenario 1: LSB-first assembly
        scenario_lsb();
        check_eq("s1_count_abs", in_word_count, 1);

        // Scenario 2: MSB-first, then a mode change mid-word
        cfg_msb_first = 1;
        send_beat(4'h5); send_beat(4'h7); send_beat(4'hB);
        check_eq("s2_msb_data", core_in_data, 11'h57B);
        send_beat(4'h5);
        cfg_msb_first = 0;
        send_beat(4'h7); send_beat(4'hB);
        check_eq("s2_midword", core_in_data, 11'h57B);
        send_beat(4'hB); send_beat(4'h7); send_beat(4'h5);
        check_eq("s2_next_lsb", core_in_data, 11'h57B);
        step();

        // Scenario 3: back-pressure on a full input FIFO
        core_in_ready = 0;
        for (int w = 0; w < 4 * NB + 2; w++) send_beat(4'($urandom_range(0, 15)));
        pad_in_valid = 1; pad_in_data = 4'h3;
        check_eq("s3_ready_low", pad_in_ready, 0);
        step();
        core_in_ready = 1;
        step();
        core_in_ready = 0;
        check_eq("s3_ready_after_pop", pad_in_ready, 1);
        step();
        pad_in_valid = 0;
        check_eq("s3_words_full", pad_in_ready, 1);
        core_in_ready = 1;
        repeat (6) step();
        core_in_ready = 0;

        // Scenario 4: serialiser ordering and latency
        pad_out_ready = 1;
        core_out_valid = 1; core_out_data = 11'h2A5;
        step();
        core_out_data = 11'h7FF;
        step();
        core_out_valid = 0;
        check_eq("s4_latency", pad_out_valid, 1);
        obs.delete();
        for (int c = 0; c < 10; c++) begin
            if (pad_out_valid) obs.push_back(int'(pad_out_data));
            step();
        end
        check_eq("s4_nbeats", obs.size(), 6);
        for (int i = 0; i < 6 && i < obs.size(); i++) check_eq("s4_beat", obs[i], exp_beats[i]);
        check_eq("s4_out_cnt", out_word_count, 2);
        core_out_valid = 1; core_out_data = 11'h123;
        step();
        core_out_valid = 0;
        step();
        pad_out_ready = 0;
        held = pad_out_data;
        repeat (3) step();
        check_eq("s4_hold", pad_out_data, held);
        pad_out_ready = 1;
        repeat (4) step();
        pad_out_ready = 0;

        // Scenario 5: flush with both FIFOs full and a partial word
        core_in_ready = 0;
        for (int b = 0; b < 4 * NB + 2; b++) send_beat(4'($urandom_range(0, 15)));
        guard = 0;
        core_out_valid = 1;
        while (core_out_ready && guard < 8) begin
            core_out_data = 11'($urandom_range(0, 2047));
            step();
            guard++;
        end
        core_out_valid = 0;
        check_eq("s5_out_full", core_out_ready, 0);
        saved_in = in_word_count; saved_out = out_word_count;
        cfg_flush = 1; pad_in_valid = 1; pad_in_data = 4'h9;
        step();
        cfg_flush = 0; pad_in_valid = 0;
        check_eq("s5_in_valid", core_in_valid, 0);
        check_eq("s5_out_valid", pad_out_valid, 0);
        check_eq("s5_pad_in_ready", pad_in_ready, 1);
        check_eq("s5_core_out_ready", core_out_ready, 1);
        check_eq("s5_in_cnt", in_word_count, saved_in);
        check_eq("s5_out_cnt", out_word_count, saved_out);
        cfg_msb_first = 1;
        send_beat(4'h2); send_beat(4'hC); send_beat(4'h1);
        check_eq("s5_new_word", core_in_data, 11'h2C1);
        core_in_ready = 1;
        step();

        // Randomised traffic
        for (int c = 0; c < 2000; c++) begin
            cfg_msb_first  = ($urandom_range(0, 15) == 0) ? ~cfg_msb_first : cfg_msb_first;
            cfg_flush      = ($urandom_range(0, 99) == 0);
            pad_in_valid   = 1'($urandom_range(0, 1));
            pad_in_data    = 4'($urandom_range(0, 15));
            core_in_ready  = ($urandom_range(0, 2) != 0);
            core_out_valid = 1'($urandom_range(0, 1));
            core_out_data  = 11'($urandom_range(0, 2047));
            pad_out_ready  = ($urandom_range(0, 3) != 0);
            step();
        end
        idle_inputs();

        // Scenario 6: asynchronous reset mid-word and mid-serialisation
        send_beat(4'h6);
        core_out_valid = 1; core_out_data = 11'h3C3;
        step();
        core_out_valid = 0;
        repeat (2) step();
        #3 rst = 1;
        #1 check_reset_outputs("rst_async");
        model_reset();
        @(posedge clk);
        #1 rst = 0;
        scenario_lsb();
        check_eq("s6_count", in_word_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
